// File: rtl/reg_writeback_queue_if.sv
// Producer, write-port and forwarding-lookup signals of the register write-back queue.
// The slave modport is the queue itself; the master modport is the pipeline/register-file side.
interface reg_writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rd;
    logic [31:0]   in_data;
    logic          hold;
    logic [4:0]    RW;
    logic [31:0]   PW;
    logic          LE;
    logic [4:0]    RA;
    logic [4:0]    RB;
    logic [4:0]    RC;
    logic          hitA;
    logic          hitB;
    logic          hitC;
    logic [31:0]   fwdA;
    logic [31:0]   fwdB;
    logic [31:0]   fwdC;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_rd, in_data, hold, RA, RB, RC,
        input  in_ready, RW, PW, LE, hitA, hitB, hitC, fwdA, fwdB, fwdC, count
    );

    modport slave (
        input  in_valid, in_rd, in_data, hold, RA, RB, RC,
        output in_ready, RW, PW, LE, hitA, hitB, hitC, fwdA, fwdB, fwdC, count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue draining one result per cycle to the register file write port,
// with youngest-match forwarding on three read addresses; push-to-LE latency 1, in_ready drops only when full and not popping.
module reg_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_writeback_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic le;
    logic ready;
    logic push;

    assign le    = rst_n && (count_q != '0) && !bus.hold;
    assign ready = rst_n && ((count_q < FULL) || le);
    // r0 writes complete the handshake but are dropped here
    assign push  = bus.in_valid && ready && (bus.in_rd != 5'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (le) begin
            head_d = head_q + AW'(1);
        end
        case ({push, le})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= bus.in_rd;
            data_q[tail_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = ready;
    assign bus.LE       = le;
    assign bus.RW       = le ? rd_q[head_q]   : 5'd0;
    assign bus.PW       = le ? data_q[head_q] : 32'd0;
    assign bus.count    = count_q;

    logic [2:0][4:0]  sel;
    logic [2:0]       hit;
    logic [2:0][31:0] fwd;
    logic [AW-1:0]    idx;

    assign sel[0] = bus.RA;
    assign sel[1] = bus.RB;
    assign sel[2] = bus.RC;

    // Walk entries oldest to youngest so the last match wins.
    always_comb begin
        hit = '0;
        fwd = '0;
        idx = '0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + AW'(k);
                if (rst_n && (CW'(k) < count_q) && (sel[p] != 5'd0) && (rd_q[idx] == sel[p])) begin
                    hit[p] = 1'b1;
                    fwd[p] = data_q[idx];
                end
            end
        end
    end

    assign bus.hitA = hit[0];
    assign bus.hitB = hit[1];
    assign bus.hitC = hit[2];
    assign bus.fwdA = fwd[0];
    assign bus.fwdB = fwd[1];
    assign bus.fwdC = fwd[2];
endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-back initiator for the 32x32 three-read/one-write register file. It buffers destination-register results from the execute/load path in an in-order queue and drains one entry per cycle onto the register file write port (RW/PW/LE). It also provides forwarding lookups on the three read-select addresses, so operand reads see pending writes that have not yet committed.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  producer offers a result
- in_ready  out  1  queue accepts the offer this cycle
- in_rd  in  5  destination register number
- in_data  in  32  result value
- hold  in  1  suppresses draining (write port busy)
- RW  out  5  register file write select
- PW  out  32  register file write data
- LE  out  1  register file write enable
- RA, RB, RC  in  5 each  lookup addresses (same values driven to the register file read selects)
- hitA, hitB, hitC  out  1 each  a pending write targets that address
- fwdA, fwdB, fwdC  out  32 each  value of the youngest pending write to that address; 0 when no hit
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; count runs 0..DEPTH.
- Push: in_valid && in_ready && in_rd != 0 writes {in_rd, in_data} at the tail, tail+1.
- Writes to r0: when in_valid && in_ready && in_rd == 0, the handshake completes but nothing is enqueued and count is unchanged.
- Pop: LE = (count != 0) && !hold && rst_n. RW/PW = head entry while LE=1, else 0. The register file captures on the same edge at which head+1.
- in_ready = rst_n && ((count < DEPTH) || LE). A push into a full queue is legal only on a pop cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Lookup: for each port X, compare RX against every valid entry, including the head being popped this cycle. hitX=1 and fwdX=data of the youngest match (the entry closest to the tail). RX==0 never hits. The lookup is purely combinational on current state; same-cycle in_* is not forwarded.
- Duplicates: multiple entries may share an rd. They drain in order, so the register file ends with the youngest value.

## Timing
- Push-to-LE latency: 1 cycle minimum. An entry pushed at edge N can first drive LE during cycle N to N+1 and commits at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- hold=1 freezes the queue contents and forces LE=0. Pushes continue while count < DEPTH.
- Reset (rst_n sampled low at an edge): head=tail=count=0 and all pending entries are discarded, including mid-drain.
  - While rst_n=0: LE=0, in_ready=0, RW=0, PW=0, hit*=0, fwd*=0.
  - First cycle after release: in_ready=1 and LE=0.
- All outputs except the stored entries are combinational from registered state and rst_n, hold and RA/RB/RC. There is no combinational path from in_valid/in_rd/in_data to any output.

## Test plan
- Single write: after reset, push rd=5, data=20 → next cycle LE=1, RW=5, PW=20; cycle after, count=0 and LE=0. Register file read of 5 returns 20.
- Fill and back-pressure: hold=1, push rd=1..4 with data 21..24 → count=4 and in_ready=0. Release hold → LE on 4 consecutive cycles with RW=1,2,3,4 in order; in_ready=1 from the first pop cycle.
- Push while full: count=4, hold=0, push rd=7/data=99 on a pop cycle → accepted, count stays 4, and rd=7 drains last.
- Forwarding: hold=1, push rd=3/10, then rd=3/11, rd=9/12; RA=3, RB=9, RC=0 → hitA=1/fwdA=11, hitB=1/fwdB=12, hitC=0/fwdC=0. Release hold → register 3 finally holds 11.
- r0 discard: push rd=0/data=55 → in_ready=1 handshake completes, count stays 0, LE never asserts.
- Reset mid-drain: 3 entries queued, rst_n=0 for one edge during draining → LE=0 immediately and count=0. After release, no stale writes occur and in_ready=1.
